// File: rtl/router_reg_pn.sv
// Purpose: router packet register stage; forwards header/payload/checksum to the FIFO write bus and checks checksum and length.
// Latency: 1 cycle data_in->dout on the direct path; held bytes leave 1+ cycles after fifo_full drops.
// Backpressure: fifo_full diverts bytes into a HOLD_DEPTH hold buffer; a push into a full buffer drops the byte and sets hold_ovf.

// Small generic FIFO used as the hold buffer. Push and pop in the same cycle are allowed when full.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         empty,
    output logic         full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy bookkeeping; flush empties the buffer without producing data.
    always_ff @(posedge clock) begin
        if (!resetn || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clock) begin
        if (resetn && !flush && do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module router_reg_pn #(
    parameter int DW          = 8,
    parameter int ADDR_W      = 2,
    parameter int NUM_PORTS   = 3,
    parameter int HOLD_DEPTH  = 2,
    parameter int PARITY_MODE = 0
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          pkt_valid,
    input  logic [DW-1:0] data_in,
    input  logic          fifo_full,
    input  logic          detect_add,
    input  logic          lfd_state,
    input  logic          ld_state,
    input  logic          laf_state,
    input  logic          full_state,
    input  logic          rst_int_reg,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          low_pkt_valid,
    output logic          parity_done,
    output logic          err,
    output logic          len_err,
    output logic          hold_empty,
    output logic          hold_ovf
);
    localparam int LW = DW - ADDR_W;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] dat;
    } hold_t;

    logic [DW-1:0] header;
    logic [DW-1:0] int_par;
    logic [DW-1:0] ext_par;
    logic [LW-1:0] pay_cnt;
    logic          dout_last;
    logic          parity_done_q;
    logic          ld_act;
    logic          laf_act;
    logic          ld_direct;
    logic          ld_push;
    logic          pop;
    logic          drop;
    logic          hold_full;
    logic          addr_ok;
    hold_t         in_byte;
    hold_t         head;

    // Checksum combine: XOR or modular add depending on PARITY_MODE.
    function automatic logic [DW-1:0] par_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (PARITY_MODE == 1) ? a + b : a ^ b;
    endfunction

    // Decode which state action wins this cycle and how the ld byte is routed.
    always_comb begin
        ld_act    = ld_state && !detect_add && !lfd_state;
        laf_act   = laf_state && !detect_add && !lfd_state && !ld_state;
        ld_direct = ld_act && !fifo_full && hold_empty;
        ld_push   = ld_act && !ld_direct && !rst_int_reg;
        pop       = (ld_act || laf_act) && !hold_empty && !fifo_full && !rst_int_reg;
        drop      = ld_push && hold_full && !pop;
        addr_ok   = 32'(data_in[ADDR_W-1:0]) < NUM_PORTS;
        in_byte   = '{last: !pkt_valid, dat: data_in};
    end

    fifo #(.W($bits(hold_t)), .DEPTH(HOLD_DEPTH)) u_hold (
        .clock    (clock),
        .resetn   (resetn),
        .flush    (rst_int_reg),
        .push     (ld_push),
        .push_dat (in_byte),
        .pop      (pop),
        .pop_dat  (head),
        .empty    (hold_empty),
        .full     (hold_full)
    );

    // FIFO write bus: a single writer per cycle (header, direct byte or hold-buffer head).
    always_ff @(posedge clock) begin
        if (!resetn) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (!detect_add && lfd_state) begin
                dout       <= header;
                dout_valid <= 1'b1;
                dout_last  <= 1'b0;
            end else if (ld_direct) begin
                dout       <= data_in;
                dout_valid <= 1'b1;
                dout_last  <= !pkt_valid;
            end else if (pop) begin
                dout       <= head.dat;
                dout_valid <= 1'b1;
                dout_last  <= head.last;
            end
        end
    end

    // Header capture, checksum accumulation and payload counting.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            header  <= '0;
            int_par <= '0;
            ext_par <= '0;
            pay_cnt <= '0;
        end else if (detect_add) begin
            if (pkt_valid && addr_ok) header <= data_in;
            int_par <= '0;
            ext_par <= '0;
            pay_cnt <= '0;
        end else if (lfd_state) begin
            int_par <= par_op(int_par, header);
        end else if (ld_act) begin
            if (pkt_valid) begin
                if (pay_cnt != '1) pay_cnt <= pay_cnt + LW'(1);
                if (!full_state)   int_par <= par_op(int_par, data_in);
            end else begin
                ext_par <= data_in;
            end
        end
    end

    // Packet-end status: parity_done follows the last byte out, checks latch on its rising edge.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            parity_done   <= 1'b0;
            parity_done_q <= 1'b0;
            err           <= 1'b0;
            len_err       <= 1'b0;
        end else begin
            parity_done_q <= parity_done;
            if (detect_add) begin
                parity_done <= 1'b0;
                err         <= 1'b0;
                len_err     <= 1'b0;
            end else begin
                if (dout_valid && dout_last) parity_done <= 1'b1;
                if (parity_done && !parity_done_q) begin
                    err     <= (int_par != ext_par);
                    len_err <= (pay_cnt != header[DW-1:ADDR_W]);
                end
            end
        end
    end

    // Sticky flags cleared by the FSM's internal-reset state.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            low_pkt_valid <= 1'b0;
            hold_ovf      <= 1'b0;
        end else if (rst_int_reg) begin
            low_pkt_valid <= 1'b0;
            hold_ovf      <= 1'b0;
        end else begin
            if (ld_act && !pkt_valid) low_pkt_valid <= 1'b1;
            if (drop)                 hold_ovf      <= 1'b1;
        end
    end
endmodule

// File: tb/tb_router_reg_pn.sv
// Directed bench for router_reg_pn: one XOR-checksum instance and one additive-checksum instance on shared stimulus.
// Each step drives inputs 1 time unit after a rising edge and samples results 1 time unit after the next edge.
// Expected values are hand-computed per packet.
module tb_router_reg_pn;
    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;

    logic [7:0] x_dout, a_dout;
    logic       x_dv, x_lpv, x_pd, x_err, x_len, x_he, x_ovf;
    logic       a_dv, a_lpv, a_pd, a_err, a_len, a_he, a_ovf;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    router_reg_pn #(.DW(8), .ADDR_W(2), .NUM_PORTS(3), .HOLD_DEPTH(2), .PARITY_MODE(0)) u_dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(x_dout), .dout_valid(x_dv),
        .low_pkt_valid(x_lpv), .parity_done(x_pd), .err(x_err), .len_err(x_len),
        .hold_empty(x_he), .hold_ovf(x_ovf)
    );

    router_reg_pn #(.DW(8), .ADDR_W(2), .NUM_PORTS(3), .HOLD_DEPTH(2), .PARITY_MODE(1)) u_dut_add (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(a_dout), .dout_valid(a_dv),
        .low_pkt_valid(a_lpv), .parity_done(a_pd), .err(a_err), .len_err(a_len),
        .hold_empty(a_he), .hold_ovf(a_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock step with the given decodes: {detect,lfd,ld,laf,full_state,rst_int}, pkt_valid, data, fifo_full.
    task automatic cyc(input logic [5:0] st, input logic pv, input logic [7:0] d, input logic ff);
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = st;
        pkt_valid = pv;
        data_in   = d;
        fifo_full = ff;
        @(posedge clock);
        #1;
    endtask

    localparam logic [5:0] IDLE = 6'b000000;
    localparam logic [5:0] DET  = 6'b100000;
    localparam logic [5:0] LFD  = 6'b010000;
    localparam logic [5:0] LD   = 6'b001000;
    localparam logic [5:0] LAF  = 6'b000100;
    localparam logic [5:0] RSTI = 6'b000001;

    initial begin
        // Reset state
        resetn = 1'b0;
        cyc(IDLE, 1'b0, 8'h00, 1'b0);
        cyc(IDLE, 1'b0, 8'h00, 1'b0);
        chk("rst_dout", x_dout, 8'h00);
        chk("rst_dv", x_dv, 1'b0);
        chk("rst_hold_empty", x_he, 1'b1);
        chk("rst_flags", {x_lpv, x_pd, x_err, x_len, x_ovf}, 5'b0);
        resetn = 1'b1;

        // XOR good packet: header 0x0D, payload 11 22 33, checksum 0D
        cyc(DET, 1'b1, 8'h0D, 1'b0);
        chk("good_det_dv", x_dv, 1'b0);
        cyc(LFD, 1'b0, 8'h00, 1'b0);
        chk("good_hdr", {x_dv, x_dout}, {1'b1, 8'h0D});
        cyc(LD, 1'b1, 8'h11, 1'b0);
        chk("good_p0", {x_dv, x_dout}, {1'b1, 8'h11});
        cyc(LD, 1'b1, 8'h22, 1'b0);
        chk("good_p1", {x_dv, x_dout}, {1'b1, 8'h22});
        cyc(LD, 1'b1, 8'h33, 1'b0);
        chk("good_p2", {x_dv, x_dout}, {1'b1, 8'h33});
        cyc(LD, 1'b0, 8'h0D, 1'b0);
        chk("good_cs", {x_dv, x_dout}, {1'b1, 8'h0D});
        chk("good_lpv", x_lpv, 1'b1);
        chk("good_pd_not_yet", x_pd, 1'b0);
        cyc(IDLE, 1'b0, 8'h00, 1'b0);
        chk("good_pd", {x_dv, x_pd}, 2'b01);
        cyc(IDLE, 1'b0, 8'h00, 1'b0);
        chk("good_err_len", {x_err, x_len}, 2'b00);

        // Bad checksum 0x0C
        cyc(DET, 1'b1, 8'h0D, 1'b0);
        chk("bad_det_clr_pd", x_pd, 1'b0);
        cyc(LFD, 1'b0, 8'h00, 1'b0);
        cyc(LD, 1'b1, 8'h11, 1'b0);
        cyc(LD, 1'b1, 8'h22, 1'b0);
        cyc(LD, 1'b1, 8'h33, 1'b0);
        cyc(LD, 1'b0, 8'h0C, 1'b0);
        chk("bad_cs", {x_dv, x_dout}, {1'b1, 8'h0C});
        cyc(IDLE, 1'b0, 8'h00, 1'b0);
        chk("bad_pd_err_early", {x_pd, x_err}, 2'b10);
        cyc(IDLE, 1'b0, 8'h00, 1'b0);
        chk("bad_err", {x_err, x_len}, 2'b10);
        cyc(RSTI, 1'b0, 8'h00, 1'b0);
        chk("rsti_lpv_clr", x_lpv, 1'b0);
        chk("rsti_keeps_err", x_err, 1'b1);
        cyc(DET, 1'b1, 8'h11, 1'b0);
        chk("det_clr_err", {x_err, x_pd}, 2'b00);

        // Length mismatch: header 0x11 (len 4), 3 payload bytes, checksum 0x11
        cyc(LFD, 1'b0, 8'h00, 1'b0);
        chk("len_hdr", {x_dv, x_dout}, {1'b1, 8'h11});
        cyc(LD, 1'b1, 8'h01, 1'b0);
        cyc(LD, 1'b1, 8'h02, 1'b0);
        cyc(LD, 1'b1, 8'h03, 1'b0);
        cyc(LD, 1'b0, 8'h11, 1'b0);
        cyc(IDLE, 1'b0, 8'h00, 1'b0);
        cyc(IDLE, 1'b0, 8'h00, 1'b0);
        chk("len_err", {x_err, x_len}, 2'b01);

        // FIFO full with HOLD_DEPTH=2: A1, A2 held, A3 dropped; checksum 0D^A1^A2^A3 = AD
        cyc(DET, 1'b1, 8'h0D, 1'b0);
        cyc(LFD, 1'b0, 8'h00, 1'b1);
        chk("ff_hdr", {x_dv, x_dout}, {1'b1, 8'h0D});
        cyc(LD, 1'b1, 8'hA1, 1'b1);
        chk("ff_push1", {x_dv, x_he}, 2'b00);
        cyc(LD, 1'b1, 8'hA2, 1'b1);
        chk("ff_push2", {x_dv, x_he, x_ovf}, 3'b000);
        cyc(LD, 1'b1, 8'hA3, 1'b1);
        chk("ff_ovf", {x_dv, x_ovf}, 2'b01);
        cyc(LAF, 1'b0, 8'h00, 1'b0);
        chk("ff_pop1", {x_dv, x_dout, x_he}, {1'b1, 8'hA1, 1'b0});
        cyc(LAF, 1'b0, 8'h00, 1'b0);
        chk("ff_pop2", {x_dv, x_dout, x_he}, {1'b1, 8'hA2, 1'b1});
        cyc(LAF, 1'b0, 8'h00, 1'b0);
        chk("ff_no_a3", x_dv, 1'b0);
        cyc(LD, 1'b0, 8'hAD, 1'b0);
        chk("ff_cs", {x_dv, x_dout}, {1'b1, 8'hAD});
        cyc(IDLE, 1'b0, 8'h00, 1'b0);
        chk("ff_pd", x_pd, 1'b1);
        cyc(IDLE, 1'b0, 8'h00, 1'b0);
        chk("ff_err_len", {x_err, x_len, x_ovf}, 3'b001);

        // Additive checksum: 0D + F0 + 20 = 1D (XOR instance sees DD, so it flags err)
        cyc(DET, 1'b1, 8'h0D, 1'b0);
        cyc(LFD, 1'b0, 8'h00, 1'b0);
        cyc(LD, 1'b1, 8'hF0, 1'b0);
        cyc(LD, 1'b1, 8'h20, 1'b0);
        cyc(LD, 1'b0, 8'h1D, 1'b0);
        chk("add_cs", {a_dv, a_dout}, {1'b1, 8'h1D});
        cyc(IDLE, 1'b0, 8'h00, 1'b0);
        chk("add_pd", a_pd, 1'b1);
        cyc(IDLE, 1'b0, 8'h00, 1'b0);
        chk("add_err", a_err, 1'b0);
        chk("xor_err_same_bytes", x_err, 1'b1);
        chk("add_len_err", a_len, 1'b1);

        // Reset mid-payload with a byte held and sticky flags set
        cyc(DET, 1'b1, 8'h0D, 1'b0);
        cyc(LFD, 1'b0, 8'h00, 1'b0);
        cyc(LD, 1'b1, 8'h11, 1'b1);
        chk("pre_rst_state", {x_he, x_ovf, x_lpv}, 3'b011);
        resetn = 1'b0;
        cyc(LD, 1'b1, 8'h22, 1'b0);
        chk("midrst_dout", {x_dv, x_dout}, {1'b0, 8'h00});
        chk("midrst_flags", {x_he, x_ovf, x_lpv, x_pd, x_err, x_len}, 6'b100000);
        chk("midrst_add_flags", {a_he, a_ovf, a_lpv, a_dv}, 4'b1000);
        resetn = 1'b1;

        // Invalid address 3: header stays at its reset value
        cyc(DET, 1'b1, 8'h13, 1'b0);
        cyc(LFD, 1'b0, 8'h00, 1'b0);
        chk("bad_addr_hdr", {x_dv, x_dout}, {1'b1, 8'h00});

        cyc(IDLE, 1'b0, 8'h00, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
